// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STAG = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold max(HOLD_CYCLES, STAGGER) without wrapping.
    function automatic int count_width(input int hold_cycles, input int stagger);
        return $clog2(max_int(hold_cycles, stagger) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_req_sync.sv
// N-bit two-flop synchroniser for asynchronous reset requests.
module req_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Sequences peripheral and core resets from power-on and runtime requests,
// releasing peripherals first and the core STAGGER cycles later.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int SYNC_REQ    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_mask,
    output logic             rst_n_periph,
    output logic             rst_n_core,
    output logic [N_REQ-1:0] cause,
    output logic             cause_por,
    output logic             busy,
    output state_t           state
);

    localparam int CW = count_width(HOLD_CYCLES, STAGGER);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] eff;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    state_t           state_d;
    logic [N_REQ-1:0] cause_d;
    logic             cause_por_d;

    generate
        if (SYNC_REQ != 0) begin : g_sync
            req_sync #(.WIDTH(N_REQ)) u_req_sync (
                .clk (clk),
                .rst (rst),
                .d   (req),
                .q   (req_s)
            );
        end else begin : g_raw
            assign req_s = req;
        end
    endgenerate

    assign eff = req_s & req_mask;

    always_comb begin
        state_d     = state;
        count_d     = (count == COUNT_MAX) ? count : count + 1'b1;
        cause_d     = cause;
        cause_por_d = cause_por;
        case (state)
            HOLD: begin
                if (|eff) begin
                    count_d = '0;
                    cause_d = cause | eff;
                end else if (count == HOLD_LAST) begin
                    count_d = '0;
                    state_d = (STAGGER == 0) ? RUN : STAG;
                end
            end
            STAG: begin
                // A request during the stagger aborts release before the core ever runs.
                if (|eff) begin
                    state_d     = HOLD;
                    count_d     = '0;
                    cause_d     = eff;
                    cause_por_d = 1'b0;
                end else if (count == STAG_LAST) begin
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                count_d = '0;
                if (|eff) begin
                    state_d     = HOLD;
                    cause_d     = eff;
                    cause_por_d = 1'b0;
                end
            end
            default: begin
                state_d = HOLD;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HOLD;
            count        <= '0;
            rst_n_periph <= 1'b0;
            rst_n_core   <= 1'b0;
            cause        <= '0;
            cause_por    <= 1'b1;
            busy         <= 1'b1;
        end else begin
            state        <= state_d;
            count        <= count_d;
            rst_n_periph <= (state_d != HOLD);
            rst_n_core   <= (state_d == RUN);
            cause        <= cause_d;
            cause_por    <= cause_por_d;
            busy         <= (state_d != RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance (16/4, synchronised) and a
// short unsynchronised instance with no stagger, both checked against a quiet-cycle model.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int N      = 3;
    localparam int HOLD_A = 16;
    localparam int STAG_A = 4;
    localparam int HOLD_B = 5;
    localparam int STAG_B = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] req_mask;

    logic         periph_a, core_a, por_a, busy_a;
    logic [N-1:0] cause_a;
    state_t       state_a;
    logic         periph_b, core_b, por_b, busy_b;
    logic [N-1:0] cause_b;
    state_t       state_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.N_REQ(N), .HOLD_CYCLES(HOLD_A), .STAGGER(STAG_A), .SYNC_REQ(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .req_mask(req_mask),
        .rst_n_periph(periph_a), .rst_n_core(core_a), .cause(cause_a),
        .cause_por(por_a), .busy(busy_a), .state(state_a)
    );

    reset_sequencer #(.N_REQ(N), .HOLD_CYCLES(HOLD_B), .STAGGER(STAG_B), .SYNC_REQ(0)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .req_mask(req_mask),
        .rst_n_periph(periph_b), .rst_n_core(core_b), .cause(cause_b),
        .cause_por(por_b), .busy(busy_b), .state(state_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count eff-free edges since the last request or rst; outputs follow from thresholds.
    int           m_hold[2] = '{HOLD_A, HOLD_B};
    int           m_stag[2] = '{STAG_A, STAG_B};
    bit           m_sync[2] = '{1'b1, 1'b0};
    int           m_quiet[2];
    logic [N-1:0] m_cause[2];
    logic         m_por[2];
    logic [N-1:0] m_h1[2];
    logic [N-1:0] m_h2[2];
    logic [N-1:0] m_eff;

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_quiet[i] = 0;
                m_cause[i] = '0;
                m_por[i]   = 1'b1;
                m_h1[i]    = '0;
                m_h2[i]    = '0;
            end else begin
                m_eff   = (m_sync[i] ? m_h2[i] : req) & req_mask;
                m_h2[i] = m_h1[i];
                m_h1[i] = req;
                if (m_eff != '0) begin
                    if (m_quiet[i] >= m_hold[i]) begin
                        m_cause[i] = m_eff;
                        m_por[i]   = 1'b0;
                    end else begin
                        m_cause[i] = m_cause[i] | m_eff;
                    end
                    m_quiet[i] = 0;
                end else if (m_quiet[i] < m_hold[i] + m_stag[i]) begin
                    m_quiet[i]++;
                end
            end
        end
    end

    task automatic compare_inst(input int i, input logic periph, input logic core,
                                input logic busy, input logic [N-1:0] cause,
                                input logic por, input logic [1:0] st);
        logic [1:0] exp_st;
        string      tag;
        tag = (i == 0) ? "a" : "b";
        if (m_quiet[i] < m_hold[i])                    exp_st = 2'd0;
        else if (m_quiet[i] < m_hold[i] + m_stag[i])   exp_st = 2'd1;
        else                                           exp_st = 2'd2;
        check({tag, ".periph"}, periph, m_quiet[i] >= m_hold[i]);
        check({tag, ".core"},   core,   m_quiet[i] >= m_hold[i] + m_stag[i]);
        check({tag, ".busy"},   busy,   m_quiet[i] <  m_hold[i] + m_stag[i]);
        check({tag, ".cause"},  cause,  m_cause[i]);
        check({tag, ".por"},    por,    m_por[i]);
        check({tag, ".state"},  st,     exp_st);
    endtask

    always @(negedge clk) begin
        compare_inst(0, periph_a, core_a, busy_a, cause_a, por_a, state_a);
        compare_inst(1, periph_b, core_b, busy_b, cause_b, por_b, state_b);
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_mask = 3'b111;
        repeat (3) @(negedge clk);
        check("rst.periph", periph_a, 0);
        check("rst.core",   core_a,   0);
        check("rst.busy",   busy_a,   1);
        check("rst.cause",  cause_a,  0);
        check("rst.por",    por_a,    1);
        check("rst.state",  state_a,  HOLD);

        // Power-on release: periph on edge 16, core on edge 20; B releases both on edge 5.
        rst = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 15) check("por.periph15", periph_a, 0);
            if (k == 16) check("por.periph16", periph_a, 1);
            if (k == 16) check("por.core16",   core_a,   0);
            if (k == 19) check("por.core19",   core_a,   0);
            if (k == 20) check("por.core20",   core_a,   1);
            if (k == 20) check("por.busy20",   busy_a,   0);
            if (k == 20) check("por.cause",    cause_a,  0);
            if (k == 20) check("por.por",      por_a,    1);
            if (k == 4)  check("b.por.both4",  {periph_b, core_b}, 2'b00);
            if (k == 5)  check("b.por.both5",  {periph_b, core_b}, 2'b11);
        end

        // One-cycle runtime request on req[1].
        req = 3'b010;
        @(negedge clk);
        check("rt.edge1", periph_a, 1);
        check("rt.b.edge1", {periph_b, core_b}, 2'b00);
        check("rt.b.cause", cause_b, 3'b010);
        req = '0;
        @(negedge clk);
        check("rt.edge2", periph_a, 1);
        @(negedge clk);
        check("rt.edge3", {periph_a, core_a}, 2'b00);
        check("rt.cause", cause_a, 3'b010);
        check("rt.por",   por_a,   0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) check("rt.periph15", periph_a, 0);
            if (k == 16) check("rt.periph16", periph_a, 1);
        end

        // Stagger abort: request lands while A is in STAG.
        req = 3'b001;
        @(negedge clk);
        req = '0;
        check("abort.core1", core_a, 0);
        @(negedge clk);
        check("abort.core2", core_a, 0);
        @(negedge clk);
        check("abort.periph", periph_a, 0);
        check("abort.state",  state_a,  HOLD);
        check("abort.cause",  cause_a,  3'b001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort.core_low", core_a, 0);
        end
        repeat (25) @(negedge clk);
        check("abort.run", busy_a, 0);

        // Held request for 40 cycles.
        req = 3'b001;
        repeat (40) @(negedge clk);
        check("held.periph", periph_a, 0);
        req = '0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) check("held.periph17", periph_a, 0);
            if (k == 18) check("held.periph18", periph_a, 1);
        end
        check("held.cause", cause_a, 3'b001);
        repeat (8) @(negedge clk);
        check("held.run", busy_a, 0);

        // Masked request has no effect; two simultaneous requests are both recorded.
        req_mask = 3'b011;
        req      = 3'b100;
        repeat (6) @(negedge clk);
        check("mask.periph", periph_a, 1);
        check("mask.busy",   busy_a,   0);
        check("mask.cause",  cause_a,  3'b001);
        req = 3'b011;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        check("multi.periph", periph_a, 0);
        check("multi.cause",  cause_a,  3'b011);

        // Asynchronous rst mid-HOLD at count 10.
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.periph", periph_a, 0);
        check("arst.core",   core_a,   0);
        check("arst.busy",   busy_a,   1);
        check("arst.cause",  cause_a,  0);
        check("arst.por",    por_a,    1);
        check("arst.state",  state_a,  HOLD);
        check("arst.b.cause", cause_b, 0);
        @(negedge clk);
        req_mask = 3'b111;
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) check("arst.b.both4", {periph_b, core_b}, 2'b00);
            if (k == 5) check("arst.b.both5", {periph_b, core_b}, 2'b11);
        end

        // Random requests, masks and gaps; the model covers every cycle.
        for (int n = 0; n < 200; n++) begin
            req_mask = N'($urandom_range(0, 7));
            req      = N'($urandom_range(1, 7));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            req = '0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        req = '0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences the system resets of the tinyecp5 FPGA top from power-on and from runtime reset requests (debug ndmreset, watchdog, user button). It drives separate peripheral and core reset outputs, releasing peripherals first and the core a fixed stagger later. It records which request caused the most recent reset. It sits between the FPGA-level reset source and the SoC's reset inputs.

## Interface
- `N_REQ`, default 3: number of reset-request inputs.
- `HOLD_CYCLES`, default 16: minimum cycles both resets stay asserted; must be at least 1.
- `STAGGER`, default 4: cycles between peripheral release and core release; 0 means both release together.
- `SYNC_REQ`, default 1: when 1, `req` passes through a 2-flop synchroniser; when 0, `req` is used directly and must already be synchronous to `clk`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: level reset requests. Any masked-in bit that is high forces reset.
- `req_mask` in N_REQ: per-request enable, synchronous to `clk`.
- `rst_n_periph` out 1: active-low peripheral reset, registered.
- `rst_n_core` out 1: active-low core reset, registered.
- `cause` out N_REQ: sticky record of the requests that caused the last reset.
- `cause_por` out 1: high when the last reset came from `rst`.
- `busy` out 1: high while not in RUN.

## Operation
- Effective request: `eff = req_s & req_mask`, where `req_s` is the synchronised `req` or raw `req` depending on `SYNC_REQ`.
- States: HOLD, STAG, RUN.
- Reset values while `rst` is high:
  - state = HOLD, count = 0.
  - `rst_n_periph` = 0, `rst_n_core` = 0.
  - `cause` = 0, `cause_por` = 1, `busy` = 1.
- HOLD:
  - Both resets asserted.
  - If `|eff`, count returns to 0 and `cause |= eff`.
  - Otherwise count increments.
  - When count reaches HOLD_CYCLES-1 with `eff` == 0: count goes to 0 and `rst_n_periph` goes to 1.
    - If STAGGER == 0, `rst_n_core` also goes to 1 and the next state is RUN.
    - Otherwise the next state is STAG.
- STAG:
  - `rst_n_periph` = 1 and count increments.
  - When count reaches STAGGER-1: `rst_n_core` goes to 1 and the next state is RUN.
  - If `|eff`, go to HOLD and apply the RUN request actions below.
- RUN:
  - Both resets released and `busy` = 0.
  - If `|eff`: next state is HOLD, both resets go to 0, count goes to 0, `cause` is replaced by `eff`, and `cause_por` goes to 0.
- A request held high keeps the block in HOLD indefinitely; reset release waits for deassertion.
- Simultaneous requests are all recorded in `cause`; none has priority.
- A request that is masked out has no effect and is not recorded.
- `rst` assertion in any state forces reset values immediately, asynchronously.
- Counter width is `$clog2(max(HOLD_CYCLES, STAGGER) + 1)`. The counter saturates and never wraps.

## Timing
- All outputs are registered and change only on `clk` edges, except the asynchronous assertion on `rst`.
- After `rst` falls with no requests pending:
  - `rst_n_periph` rises on the HOLD_CYCLES-th rising edge.
  - `rst_n_core` rises STAGGER edges after that.
  - `busy` falls on the same edge as `rst_n_core`.
- Request-to-reset latency is 1 cycle after `eff` is high, plus 2 cycles when SYNC_REQ = 1.
- On any reset-assert transition, both resets assert on the same edge.

## Structure
- Shared package `reset_sequencer_pkg` holds the state encoding: HOLD = 2'd0, STAG = 2'd1, RUN = 2'd2.
- One sub-module, `req_sync`: an N_REQ-wide 2-flop synchroniser using the same `rst`. It is instantiated only when SYNC_REQ = 1.
- The state machine, counter and cause logic stay in the top module.

## Test plan
- **POR release.** Defaults, `rst` pulsed then released, `req` = 0 → `rst_n_periph` rises on edge 16, `rst_n_core` on edge 20, `cause_por` = 1, `cause` = 0.
- **Runtime request.** In RUN, `req_mask` = 3'b111, `req[1]` pulsed for 1 cycle → both resets low 3 edges later (SYNC_REQ = 1). Then `cause` = 3'b010, `cause_por` = 0, and release follows the same 16/4 sequence.
- **Held request.** `req[0]` held high for 40 cycles in RUN → resets stay low until 16 cycles after `req[0]` falls (plus sync latency). Then `cause` = 3'b001.
- **Masked request.** `req_mask` = 3'b011, `req[2]` high → no reset, `cause` unchanged. Then `req[0]` and `req[1]` asserted on the same cycle → `cause` = 3'b011.
- **Stagger abort.** Request arrives while in STAG → `rst_n_periph` goes low again, state returns to HOLD, and `rst_n_core` never pulses high.
- **Mid-sequence rst.** `rst` asserted asynchronously during HOLD with count = 10 → all reset values seen immediately, without waiting for a clock edge. With STAGGER = 0, both resets rise on the same edge.
